// File: rtl/snn_pkg.sv
// Shared definitions for the spike dispatcher: default address width,
// dispatcher FSM encoding and configuration table select codes.
package snn_pkg;

  localparam int ADDR_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

  localparam logic [1:0] CFG_ADDR = 2'd0;
  localparam logic [1:0] CFG_PTR  = 2'd1;
  localparam logic [1:0] CFG_CONN = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra wrap bit on each pointer; data is read from
// the head combinationally. Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spike_dispatcher.sv
// Turns per-neuron spike strobes into a stream of {origin, destination} packets
// by walking each spiking neuron's slice of the downstream connection table.
// Packet port: pkt_valid means a head entry exists; it is consumed on any rising
// edge where pkt_valid and pkt_ready are both 1, and holds steady otherwise.
module spike_dispatcher
  import snn_pkg::*;
#(
  parameter  int NUM_NEURONS = 10,
  parameter  int ADDR_W      = ADDR_W_DEF,
  parameter  int MAX_CONN    = 64,
  parameter  int FIFO_DEPTH  = 8,
  localparam int PTR_W       = $clog2(MAX_CONN)
) (
  input  logic                   CLK,
  input  logic                   clear,
  input  logic [NUM_NEURONS-1:0] spike,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_sel,
  input  logic [PTR_W-1:0]       cfg_idx,
  input  logic [31:0]            cfg_data,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic [ADDR_W-1:0]      pkt_origin,
  output logic [ADDR_W-1:0]      pkt_dest,
  output logic                   busy,
  output logic [15:0]            drop_count,
  output state_t                 dbg_state
);

  localparam int NN_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int CNT_W = PTR_W + 1;

  state_t                 state;
  logic [NUM_NEURONS-1:0] pending;
  logic [NUM_NEURONS-1:0] clr_mask;
  logic [NUM_NEURONS-1:0] drop_hits;
  logic [NN_W-1:0]        rr_ptr;
  logic [NN_W-1:0]        sel_r;
  logic [NN_W-1:0]        pick;
  logic                   pick_found;

  logic [ADDR_W-1:0] addr_tab [NUM_NEURONS];
  logic [PTR_W-1:0]  base_tab [NUM_NEURONS];
  logic [CNT_W-1:0]  cnt_tab  [NUM_NEURONS];
  logic [ADDR_W-1:0] conn_tab [MAX_CONN];

  logic [ADDR_W-1:0] origin_r;
  logic [PTR_W-1:0]  ptr_r;
  logic [CNT_W-1:0]  rem_r;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic [2*ADDR_W-1:0] fifo_din;
  logic [2*ADDR_W-1:0] fifo_dout;

  logic             cfg_ok;
  logic             nidx_ok;
  logic             cidx_ok;
  logic [NN_W-1:0]  nidx;
  logic [CNT_W-1:0] cfg_cnt_raw;
  logic [CNT_W-1:0] cfg_cnt;
  logic [16:0]      n_drop;
  logic [16:0]      drop_sum;
  logic             cfg_unused;

  assign busy      = (state != ST_IDLE) || (|pending) || !fifo_empty;
  assign dbg_state = state;

  // Configuration is only accepted while fully quiescent.
  assign cfg_ok      = cfg_we && !busy;
  assign nidx        = NN_W'(cfg_idx);
  assign nidx_ok     = int'(cfg_idx) < NUM_NEURONS;
  assign cidx_ok     = int'(cfg_idx) < MAX_CONN;
  assign cfg_cnt_raw = cfg_data[PTR_W+16:16];
  assign cfg_cnt     = (cfg_cnt_raw > CNT_W'(MAX_CONN)) ? CNT_W'(MAX_CONN) : cfg_cnt_raw;
  assign cfg_unused  = ^cfg_data;

  // Round-robin pick: first pending neuron at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int off = 0; off < NUM_NEURONS; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_NEURONS) idx = idx - NUM_NEURONS;
      if (!pick_found && pending[idx]) begin
        pick_found = 1'b1;
        pick       = NN_W'(idx);
      end
    end
  end

  always_comb begin
    clr_mask = '0;
    if (state == ST_IDLE && pick_found) clr_mask[pick] = 1'b1;
  end

  assign drop_hits = spike & pending;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NUM_NEURONS; i++) n_drop = n_drop + 17'(drop_hits[i]);
    drop_sum = {1'b0, drop_count} + n_drop;
  end

  always_ff @(posedge CLK or negedge clear) begin
    if (!clear) begin
      pending    <= '0;
      drop_count <= '0;
    end else begin
      // A fresh spike wins over the arbiter's clear in the same cycle.
      pending    <= (pending & ~clr_mask) | spike;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (cfg_ok) begin
      case (cfg_sel)
        CFG_ADDR: if (nidx_ok) addr_tab[nidx] <= cfg_data[ADDR_W-1:0];
        CFG_PTR:  if (nidx_ok) base_tab[nidx] <= cfg_data[PTR_W-1:0];
        CFG_CONN: if (cidx_ok) conn_tab[cfg_idx] <= cfg_data[ADDR_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_NEURONS; i++) cnt_tab[i] <= '0;
    end else if (cfg_ok && cfg_sel == CFG_PTR && nidx_ok) begin
      cnt_tab[nidx] <= cfg_cnt;
    end
  end

  always_ff @(posedge CLK or negedge clear) begin
    if (!clear) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      sel_r    <= '0;
      origin_r <= '0;
      ptr_r    <= '0;
      rem_r    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            sel_r  <= pick;
            rr_ptr <= (int'(pick) == NUM_NEURONS - 1) ? '0 : pick + NN_W'(1);
            state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          origin_r <= addr_tab[sel_r];
          ptr_r    <= base_tab[sel_r];
          rem_r    <= cnt_tab[sel_r];
          state    <= (cnt_tab[sel_r] == '0) ? ST_IDLE : ST_EMIT;
        end
        ST_EMIT: begin
          if (!fifo_full) begin
            ptr_r <= (int'(ptr_r) == MAX_CONN - 1) ? '0 : ptr_r + PTR_W'(1);
            rem_r <= rem_r - CNT_W'(1);
            if (rem_r == CNT_W'(1)) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Full is sampled before any same-cycle pop, so a full FIFO always stalls EMIT.
  assign fifo_push = (state == ST_EMIT) && !fifo_full;
  assign fifo_din  = {origin_r, conn_tab[ptr_r]};
  assign fifo_pop  = pkt_ready && !fifo_empty;

  sync_fifo #(
    .WIDTH (2*ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (clear),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign pkt_valid  = !fifo_empty;
  assign pkt_origin = fifo_dout[2*ADDR_W-1:ADDR_W];
  assign pkt_dest   = fifo_dout[ADDR_W-1:0];

endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed bench for spike_dispatcher: hand-computed packet bursts fed into an
// expected queue, latency/stall/reset spot checks, and a one-line report.
module tb_spike_dispatcher;
  import snn_pkg::*;

  localparam int NN = 10;
  localparam int AW = 12;
  localparam int MC = 64;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          clear;
  logic [NN-1:0] spike;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [PW-1:0] cfg_idx;
  logic [31:0]   cfg_data;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [AW-1:0] pkt_origin;
  logic [AW-1:0] pkt_dest;
  logic          busy;
  logic [15:0]   drop_count;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [2*AW-1:0] exp_q[$];
  logic [AW-1:0]   conn_m[MC];

  spike_dispatcher #(
    .NUM_NEURONS (NN),
    .ADDR_W      (AW),
    .MAX_CONN    (MC),
    .FIFO_DEPTH  (8)
  ) dut (
    .CLK        (CLK),
    .clear      (clear),
    .spike      (spike),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_idx    (cfg_idx),
    .cfg_data   (cfg_data),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_origin (pkt_origin),
    .pkt_dest   (pkt_dest),
    .busy       (busy),
    .drop_count (drop_count),
    .dbg_state  (dbg_state)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted packet must match the head of exp_q.
  always @(negedge CLK) begin
    logic [31:0] e;
    if (clear && pkt_valid && pkt_ready) begin
      if (exp_q.size() > 0) e = {8'h00, exp_q.pop_front()};
      else                  e = 32'hDEAD_BEEF;
      check("pkt", {8'h00, pkt_origin, pkt_dest}, e);
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input int idx, input logic [31:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_idx  = PW'(idx);
    cfg_data = data;
    tick(1);
    cfg_we   = 1'b0;
  endtask

  task automatic set_conn(input int i, input logic [AW-1:0] v);
    cfg_write(CFG_CONN, i, {20'h0, v});
    conn_m[i] = v;
  endtask

  task automatic set_ptr(input int n, input int base, input int cnt);
    cfg_write(CFG_PTR, n, (32'(cnt) << 16) | 32'(base));
  endtask

  task automatic pulse(input logic [NN-1:0] m);
    spike = m;
    tick(1);
    spike = '0;
  endtask

  task automatic push_burst(input logic [AW-1:0] origin, input int base, input int cnt);
    for (int k = 0; k < cnt; k++) exp_q.push_back({origin, conn_m[(base + k) % MC]});
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic apply_reset(input string tag);
    clear = 1'b0;
    #1;
    check({tag, "_valid"}, {31'h0, pkt_valid}, 32'h0);
    check({tag, "_busy"},  {31'h0, busy}, 32'h0);
    check({tag, "_state"}, {30'h0, dbg_state}, 32'(ST_IDLE));
    check({tag, "_drop"},  {16'h0, drop_count}, 32'h0);
    exp_q.delete();
    tick(1);
    clear = 1'b1;
    tick(1);
  endtask

  initial begin
    clear = 1'b0; spike = '0; cfg_we = 1'b0; cfg_sel = '0;
    cfg_idx = '0; cfg_data = '0; pkt_ready = 1'b0;
    tick(2);
    check("rst_valid", {31'h0, pkt_valid}, 32'h0);
    check("rst_busy",  {31'h0, busy}, 32'h0);
    check("rst_drop",  {16'h0, drop_count}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'(ST_IDLE));
    clear = 1'b1;
    tick(1);

    for (int i = 0; i < NN; i++) cfg_write(CFG_ADDR, i, 32'h0A0 + 32'(i));
    for (int i = 0; i < MC; i++) set_conn(i, AW'(12'h200 + i));
    set_conn(4, 12'd5);
    set_conn(5, 12'd7);
    set_conn(6, 12'd9);

    // Single 3-packet burst and first-packet latency
    set_ptr(2, 4, 3);
    push_burst(12'h0A2, 4, 3);
    pulse(10'b00_0000_0100);
    check("lat_k0", {31'h0, pkt_valid}, 32'h0);
    tick(1); check("lat_k1", {31'h0, pkt_valid}, 32'h0);
    tick(1); check("lat_k2", {31'h0, pkt_valid}, 32'h0);
    tick(1); check("lat_k3", {31'h0, pkt_valid}, 32'h1);
    check("head_origin", {20'h0, pkt_origin}, 32'h0A2);
    check("head_dest",   {20'h0, pkt_dest},   32'h005);
    pkt_ready = 1'b1;
    wait_idle(50, "t035_idle");
    check("t035_drop", {16'h0, drop_count}, 32'h0);

    // FIFO-full stall, coalesced spikes and a discarded busy write
    pkt_ready = 1'b0;
    set_ptr(0, 10, 12);
    push_burst(12'h0A0, 10, 12);
    pulse(10'b00_0000_0001);
    tick(14);
    check("stall_state", {30'h0, dbg_state}, 32'(ST_EMIT));
    check("stall_valid", {31'h0, pkt_valid}, 32'h1);
    check("stall_busy",  {31'h0, busy}, 32'h1);
    check("stall_head",  {8'h00, pkt_origin, pkt_dest}, {8'h00, 12'h0A0, 12'h20A});
    spike = 10'b00_0000_0100;
    tick(3);
    spike = '0;
    check("coalesce_drop", {16'h0, drop_count}, 32'h2);
    cfg_write(CFG_ADDR, 2, 32'h777);
    push_burst(12'h0A2, 4, 3);
    pkt_ready = 1'b1;
    wait_idle(100, "t038_idle");
    check("t038_drop", {16'h0, drop_count}, 32'h2);

    // All neurons at once: round-robin from 0 after reset
    apply_reset("rst2");
    for (int i = 0; i < NN; i++) set_ptr(i, 30 + i, 1);
    for (int i = 0; i < NN; i++) push_burst(AW'(12'h0A0 + i), 30 + i, 1);
    pulse(10'h3FF);
    wait_idle(100, "t037_idle");
    check("t037_drop", {16'h0, drop_count}, 32'h0);

    // Pointer wrap at the end of the connection table, back-to-back packets
    set_ptr(5, 62, 4);
    push_burst(12'h0A5, 62, 4);
    pulse(10'b00_0010_0000);
    tick(2);
    for (int c = 0; c < 4; c++) begin
      tick(1);
      check("tput_valid", {31'h0, pkt_valid}, 32'h1);
    end
    tick(1);
    check("tput_end_valid", {31'h0, pkt_valid}, 32'h0);
    check("tput_end_busy",  {31'h0, busy}, 32'h0);

    // Count above MAX_CONN is clamped to a full table walk
    set_ptr(7, 0, 100);
    push_burst(12'h0A7, 0, 64);
    pulse(10'b00_1000_0000);
    wait_idle(300, "clamp_idle");
    check("clamp_left", 32'(exp_q.size()), 32'h0);

    // Reset mid-EMIT discards packets; counts reset, tables retained
    pkt_ready = 1'b0;
    set_ptr(3, 40, 20);
    pulse(10'b00_0000_1000);
    tick(8);
    check("mid_state", {30'h0, dbg_state}, 32'(ST_EMIT));
    cfg_write(CFG_CONN, 40, 32'hABC);
    apply_reset("rst3");
    pulse(10'b00_0000_1000);
    tick(4);
    check("zero_cnt_valid", {31'h0, pkt_valid}, 32'h0);
    check("zero_cnt_busy",  {31'h0, busy}, 32'h0);
    set_ptr(3, 40, 1);
    push_burst(12'h0A3, 40, 1);
    pkt_ready = 1'b1;
    pulse(10'b00_0000_1000);
    wait_idle(50, "t040_idle");
    check("final_queue", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spike_dispatcher.md
SPIKE_DISPATCHER -- requirements
Module: spike_dispatcher

Interface
REQ-001 Parameter NUM_NEURONS, default 10, number of spike inputs and neuron table entries.
REQ-002 Parameter ADDR_W, default 12, width of neuron addresses.
REQ-003 Parameter MAX_CONN, default 64, depth of the downstream connection table; PTR_W = $clog2(MAX_CONN).
REQ-004 Parameter FIFO_DEPTH, default 8, packet FIFO depth, power of two >= 2.
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 clear  in  1  reset, asynchronous, active-low.
REQ-007 spike  in  NUM_NEURONS  per-neuron spike strobes, sampled every rising edge.
REQ-008 cfg_we  in  1  configuration write strobe.
REQ-009 cfg_sel  in  2  table select: 0 neuron address, 1 connection pointer, 2 downstream connection.
REQ-010 cfg_idx  in  PTR_W  table entry index.
REQ-011 cfg_data  in  32  write data: sel 0 [ADDR_W-1:0] address; sel 1 [PTR_W-1:0] base, [PTR_W+16:16] count; sel 2 [ADDR_W-1:0] destination.
REQ-012 pkt_valid  out  1  packet available.
REQ-013 pkt_ready  in  1  consumer accepts packet.
REQ-014 pkt_origin  out  ADDR_W  address of the spiking neuron.
REQ-015 pkt_dest  out  ADDR_W  destination neuron index.
REQ-016 busy  out  1  FSM not IDLE, or pending mask nonzero, or FIFO nonempty.
REQ-017 drop_count  out  16  saturating count of coalesced spikes.

Function
REQ-018 Each edge, pending[i] SHALL be set when spike[i]=1; set SHALL win over a same-cycle clear of pending[i].
REQ-019 A spike on neuron i with pending[i] already 1 SHALL increment drop_count, saturating at 16'hFFFF.
REQ-020 FSM states SHALL be IDLE, LOOKUP, EMIT.
REQ-021 IDLE: if pending nonzero, select the first set bit at or after rr_ptr (wrapping), clear it, set rr_ptr to selected+1 mod NUM_NEURONS, go LOOKUP.
REQ-022 LOOKUP: load origin address, base and count of the selected neuron; count=0 -> IDLE, else EMIT.
REQ-023 EMIT: each cycle with FIFO not full, push {origin, conn[ptr]}, ptr increments modulo MAX_CONN, remaining decrements; after the push with remaining=1, go IDLE.
REQ-024 EMIT with FIFO full SHALL stall with no push; full is evaluated before the same-cycle pop.
REQ-025 pkt_valid SHALL equal FIFO nonempty; pkt_origin/pkt_dest SHALL show the head entry; pop occurs when pkt_valid and pkt_ready are both 1.
REQ-026 Packet order SHALL equal push order; no packet is lost or duplicated.
REQ-027 A spike sampled at edge k on an idle block with empty FIFO SHALL produce pkt_valid=1 after edge k+3.
REQ-028 With pkt_ready held 1, one packet per cycle SHALL be sustained during EMIT.
REQ-029 cfg_we SHALL be honoured only when busy=0; writes while busy=1 SHALL be discarded.
REQ-030 Pointer counts greater than MAX_CONN SHALL be clamped to MAX_CONN.

Reset
REQ-031 clear=0 SHALL immediately force: state IDLE, pending 0, rr_ptr 0, FIFO empty, pkt_valid 0, drop_count 0, busy 0, all pointer counts 0.
REQ-032 Neuron address and connection tables SHALL NOT be reset; reset mid-EMIT SHALL discard all in-flight packets.

Structure
REQ-033 Shared package snn_pkg SHALL hold default ADDR_W, FSM state encoding and cfg_sel codes.
REQ-034 The packet buffer SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH).

Verification
REQ-035 Neuron 2 addr 0x0A2, base 4, count 3, conn[4..6]=5,7,9; pulse spike[2] -> packets (0x0A2,5),(0x0A2,7),(0x0A2,9), first valid at edge k+3.
REQ-036 spike[2] high 3 consecutive cycles before selection -> drop_count=2, single 3-packet burst.
REQ-037 spike=10'h3FF simultaneously, count 1 each -> origins served 0,1,...,9 in order.
REQ-038 FIFO_DEPTH 8, count 12, pkt_ready=0 -> pkt_valid stays 1, FSM stalls in EMIT after 8 pushes; pkt_ready=1 -> remaining 4 packets delivered in order.
REQ-039 Base 62, count 4, MAX_CONN 64 -> destinations from conn[62],[63],[0],[1].
REQ-040 clear=0 asserted mid-EMIT -> pkt_valid 0 and busy 0 immediately; cfg write while busy=1 leaves table unchanged.
